// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side frame logic.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    SEND,
    WAIT
  } state_t;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;

  // Wide enough to index a frame of up to 8 data characters plus header and checksum.
  localparam int CNT_W = 4;

endpackage

// File: rtl/tx_frame_mux.sv
// Selects the frame character for a given position: header, a result byte
// (least-significant first) or the running checksum.
module tx_frame_mux
  import uart_pkg::*;
#(
  parameter int              DBIT   = 8,
  parameter int              NBYTES = 2,
  parameter int              HDR_EN = 0,
  parameter logic [DBIT-1:0] HDR    = DBIT'(HDR_DEFAULT),
  parameter int              CHK_EN = 0
) (
  input  logic [NBYTES*DBIT-1:0] shadow,
  input  logic [CNT_W-1:0]       idx,
  input  logic [DBIT-1:0]        chk,
  output logic [DBIT-1:0]        char_out,
  output logic                   is_data
);

  localparam int LEN = NBYTES + HDR_EN + CHK_EN;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  logic [DBIT-1:0] bytes [NBYTES];

  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
    assign bytes[gi] = shadow[gi*DBIT +: DBIT];
  end

  always_comb begin
    char_out = '0;
    is_data  = 1'b0;
    for (int k = 0; k < NBYTES; k++) begin
      if (idx == CNT_W'(k + HDR_EN)) begin
        char_out = bytes[k];
        is_data  = 1'b1;
      end
    end
    if (HDR_EN != 0 && idx == '0) begin
      char_out = HDR;
      is_data  = 1'b0;
    end
    if (CHK_EN != 0 && idx == LAST) begin
      char_out = chk;
      is_data  = 1'b0;
    end
  end

endmodule

// File: rtl/tx_frame_interface.sv
// Frames an ALU result into a sequence of UART characters, one frame per
// request character popped from the RX FIFO.
module tx_frame_interface
  import uart_pkg::*;
#(
  parameter int              DBIT   = 8,
  parameter int              NBYTES = 2,
  parameter int              HDR_EN = 0,
  parameter logic [DBIT-1:0] HDR    = DBIT'(HDR_DEFAULT),
  parameter int              CHK_EN = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_empty,
  input  logic                   tx_done_tick,
  input  logic [NBYTES*DBIT-1:0] result,
  output logic [DBIT-1:0]        d_in,
  output logic                   tx_start,
  output logic                   rd,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int LEN = NBYTES + HDR_EN + CHK_EN;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  state_t                 state;
  logic [CNT_W-1:0]       idx;
  logic [CNT_W-1:0]       sel;
  logic [NBYTES*DBIT-1:0] shadow;
  logic [DBIT-1:0]        chk;
  logic [DBIT-1:0]        char_sel;
  logic                   char_is_data;

  // The mux looks one character ahead so d_in is registered on the SEND entry edge.
  assign sel = (state == WAIT) ? idx + 1'b1 : '0;

  tx_frame_mux #(
    .DBIT  (DBIT),
    .NBYTES(NBYTES),
    .HDR_EN(HDR_EN),
    .HDR   (HDR),
    .CHK_EN(CHK_EN)
  ) u_mux (
    .shadow  (shadow),
    .idx     (sel),
    .chk     (chk),
    .char_out(char_sel),
    .is_data (char_is_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      shadow     <= '0;
      chk        <= '0;
      d_in       <= '0;
      tx_start   <= 1'b0;
      rd         <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      rd         <= 1'b0;
      tx_start   <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_empty) begin
            state <= POP;
            rd    <= 1'b1;
            busy  <= 1'b1;
          end
        end
        POP: begin
          // Snapshot, checksum clear and counter load land on the LOAD entry edge
          // so the first character is ready when LOAD hands over to SEND.
          state  <= LOAD;
          shadow <= result;
          chk    <= '0;
          idx    <= '0;
        end
        LOAD: begin
          state    <= SEND;
          tx_start <= 1'b1;
          d_in     <= char_sel;
          if (char_is_data) chk <= chk ^ char_sel;
        end
        SEND: begin
          state <= WAIT;
        end
        WAIT: begin
          if (tx_done_tick) begin
            if (idx == LAST) begin
              state      <= IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              state    <= SEND;
              idx      <= sel;
              tx_start <= 1'b1;
              d_in     <= char_sel;
              if (char_is_data) chk <= chk ^ char_sel;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
